// File: rtl/output_handler_pkg.sv
// Shared protocol definitions for the UART framing blocks (input_handler / output_handler):
// sync byte, command codes, FSM states and byte phases.
package output_handler_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_HASH_START  = 8'h01;
  localparam logic [7:0] CMD_DIGEST      = 8'h02;
  localparam logic [7:0] CMD_STATUS      = 8'h03;
  localparam logic [7:0] CMD_ERROR       = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE,
    ST_FINISH
  } state_e;

  typedef enum logic [2:0] {
    PH_SYNC,
    PH_CMD,
    PH_LEN,
    PH_DATA,
    PH_CSUM
  } phase_e;

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/output_handler.sv
// Serialises a result buffer as SYNC, command, length, payload [, checksum] onto a UART
// with one byte in flight. Optional checksum byte enabled by OUTPUT_HANDLER_CHECKSUM_EN.
module output_handler
  import output_handler_pkg::*;
#(
  parameter int unsigned DATA_BYTES  = 32,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    send,
  input  logic [7:0]              command,
  input  logic [7:0]              data_len,
  input  logic [8*DATA_BYTES-1:0] buffer,
  input  logic                    is_transmitting,
  output logic                    transmit,
  output logic [7:0]              tx_byte,
  output logic                    busy,
  output logic                    done,
  output logic                    tx_error
);

  localparam int unsigned BW      = 8 * DATA_BYTES;
  localparam int unsigned TW      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(ACK_TIMEOUT);
  localparam logic [7:0]  MAX_LEN = 8'(DATA_BYTES);

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      rem_q, rem_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            transmit_q, transmit_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_error_q, tx_error_d;
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic [7:0]      cur_byte;
  logic            last_byte;
  logic            advance;
  logic [TW-1:0]   tmo_inc;
  logic [7:0]      len_clamped;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_SYNC;
      cmd_q      <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      buf_q      <= '0;
      tmo_q      <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= '0;
      tx_error_q <= 1'b0;
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      buf_q      <= buf_d;
      tmo_q      <= tmo_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      tx_error_q <= tx_error_d;
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Byte currently addressed by the phase pointer; payload always sits in the top byte.
  always_comb begin
    cur_byte = '0;
    unique case (phase_q)
      PH_SYNC: cur_byte = SYNC_BYTE;
      PH_CMD:  cur_byte = cmd_q;
      PH_LEN:  cur_byte = len_q;
      PH_DATA: cur_byte = buf_q[BW-1 -: 8];
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
      PH_CSUM: cur_byte = csum_q;
`endif
      default: cur_byte = '0;
    endcase
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
    last_byte = (phase_q == PH_CSUM);
`else
    last_byte = ((phase_q == PH_LEN) && (len_q == 8'd0)) ||
                ((phase_q == PH_DATA) && (rem_q == 8'd1));
`endif
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cmd_d       = cmd_q;
    len_d       = len_q;
    rem_d       = rem_q;
    buf_d       = buf_q;
    tmo_d       = tmo_q;
    transmit_d  = 1'b0;
    tx_byte_d   = tx_byte_q;
    tx_error_d  = tx_error_q;
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    advance     = 1'b0;
    tmo_inc     = tmo_q + 1'b1;
    len_clamped = clamp_len(data_len, MAX_LEN);

    unique case (state_q)
      ST_IDLE: begin
        if (send) begin
          cmd_d      = command;
          len_d      = len_clamped;
          buf_d      = buffer;
          rem_d      = '0;
          phase_d    = PH_SYNC;
          tx_error_d = 1'b0;
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
          csum_d     = command ^ len_clamped;
`endif
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!is_transmitting) begin
          transmit_d = 1'b1;
          tx_byte_d  = cur_byte;
          tmo_d      = '0;
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (is_transmitting) begin
          state_d = ST_WAIT_IDLE;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_MAX) begin
            tx_error_d = 1'b1;
            advance    = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (!is_transmitting) advance = 1'b1;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Both completion paths (ack seen, or timeout) share one pointer-advance step.
    if (advance) begin
      state_d = last_byte ? ST_FINISH : ST_SEND;
      unique case (phase_q)
        PH_SYNC: phase_d = PH_CMD;
        PH_CMD:  phase_d = PH_LEN;
        PH_LEN: begin
          rem_d   = len_q;
          phase_d = (len_q == 8'd0) ? PH_CSUM : PH_DATA;
        end
        PH_DATA: begin
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
          csum_d = csum_q ^ buf_q[BW-1 -: 8];
`endif
          buf_d = buf_q << 8;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) phase_d = PH_CSUM;
        end
        default: phase_d = phase_q;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q == ST_SEND) || (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_IDLE);
    done     = (state_q == ST_FINISH);
    transmit = transmit_q;
    tx_byte  = tx_byte_q;
    tx_error = tx_error_q;
  end

endmodule

// File: tb/tb_output_handler.sv
// Self-checking bench for output_handler: frame contents from a queue-based reference
// model, UART behavioural model, busy/timeout/collision/reset cases.
module tb_output_handler;

  localparam int unsigned DB  = 32;
  localparam int unsigned BW  = 8 * DB;
  localparam int unsigned ACK = 15;

  logic          clk;
  logic          rst;
  logic          send;
  logic [7:0]    command;
  logic [7:0]    data_len;
  logic [BW-1:0] buffer;
  logic          is_transmitting;
  logic          transmit;
  logic [7:0]    tx_byte;
  logic          busy;
  logic          done;
  logic          tx_error;

  output_handler #(
    .DATA_BYTES (DB),
    .SYNC_BYTE  (8'hA5),
    .ACK_TIMEOUT(ACK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .send           (send),
    .command        (command),
    .data_len       (data_len),
    .buffer         (buffer),
    .is_transmitting(is_transmitting),
    .transmit       (transmit),
    .tx_byte        (tx_byte),
    .busy           (busy),
    .done           (done),
    .tx_error       (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit  dead       = 1'b0;
  bit  force_busy = 1'b0;
  int  cyc        = 0;
  int  last_pulse = -1;
  int  first_pulse = -1;
  int  send_cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame = SYNC, cmd, clamped len, payload MSB-first, optional XOR checksum.
  function automatic void model(input logic [7:0] cmd, input logic [7:0] len, input logic [BW-1:0] b);
    int unsigned n;
    logic [7:0]  cs;
    logic [7:0]  bt;
    n = (len > DB) ? DB : len;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(cmd);
    exp_q.push_back(8'(n));
    cs = cmd ^ 8'(n);
    for (int unsigned i = 0; i < n; i++) begin
      bt = b[BW-1-8*i -: 8];
      exp_q.push_back(bt);
      cs ^= bt;
    end
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  function automatic logic [BW-1:0] rand_buf();
    logic [BW-1:0] r;
    for (int unsigned k = 0; k < BW / 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // UART model (busy 1 cycle after pulse, for 10 cycles) plus pulse monitor.
  initial begin
    int  hold = 0;
    bit  pend = 1'b0;
    bit  prev_tx = 1'b0;
    is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (transmit) begin
        check_eq("pulse_while_busy", 32'(is_transmitting), 0);
        check_eq("pulse_width", 32'(prev_tx), 0);
        if (dead && last_pulse >= 0)
          check_eq("timeout_gap", 32'((cyc - last_pulse) >= ACK && (cyc - last_pulse) <= ACK + 2), 1);
        if (got_q.size() == 0) first_pulse = cyc;
        last_pulse = cyc;
        got_q.push_back(tx_byte);
      end
      prev_tx = transmit;
      if (done) begin
        check_eq("busy_at_done", 32'(busy), 0);
        last_pulse = -1;
      end
      if (hold > 0) hold--;
      if (pend) begin hold = 10; pend = 1'b0; end
      if (transmit && !dead) pend = 1'b1;
      is_transmitting = force_busy || (hold > 0);
    end
  end

  task automatic start_frame(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                             input logic [BW-1:0] b);
    model(cmd, len, b);
    got_q.delete();
    @(negedge clk);
    command = cmd; data_len = len; buffer = b; send = 1'b1;
    send_cyc = cyc;
    @(negedge clk);
    send = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 1);
    check_eq({tag, "_err_clr"}, 32'(tx_error), 0);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_done"}, 32'(seen), 1);
  endtask

  task automatic cmp_frame(input string tag);
    check_eq({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                          input logic [BW-1:0] b, input bit exp_err);
    start_frame(tag, cmd, len, b);
    wait_done(tag);
    check_eq({tag, "_err"}, 32'(tx_error), 32'(exp_err));
    cmp_frame(tag);
  endtask

  initial begin
    logic [7:0] lit[$];
    logic [BW-1:0] b;
    rst = 1'b1; send = 1'b0; command = '0; data_len = '0; buffer = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_transmit", 32'(transmit), 0);
    check_eq("rst_tx_byte", 32'(tx_byte), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_tx_error", 32'(tx_error), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame with first-pulse latency and literal bytes.
    b = '0;
    b[BW-1 -: 32] = 32'hDEADBEEF;
    start_frame("basic", 8'h02, 8'd4, b);
    @(negedge clk);
    check_eq("first_pulse_lat", 32'(transmit), 1);
    wait_done("basic");
    check_eq("basic_err", 32'(tx_error), 0);
    cmp_frame("basic");
    lit = '{8'hA5, 8'h02, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef OUTPUT_HANDLER_CHECKSUM_EN
    lit.push_back(8'h24);
`endif
    check_eq("lit_nbytes", got_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < got_q.size(); i++)
      check_eq($sformatf("lit_b%0d", i), 32'(got_q[i]), 32'(lit[i]));

    // Zero length and clamping.
    do_frame("len0", 8'h11, 8'd0, rand_buf(), 1'b0);
    do_frame("len40", 8'h12, 8'd40, rand_buf(), 1'b0);
    do_frame("len255", 8'h13, 8'd255, rand_buf(), 1'b0);

    // UART busy for 50 cycles around the request.
    force_busy = 1'b1;
    fork
      begin repeat (50) @(negedge clk); force_busy = 1'b0; end
      do_frame("uart_busy", 8'h03, 8'd3, rand_buf(), 1'b0);
    join
    check_eq("uart_busy_hold", 32'((first_pulse - send_cyc) >= 49), 1);

    // Timeout: UART never acknowledges.
    dead = 1'b1;
    do_frame("timeout", 8'h04, 8'd2, rand_buf(), 1'b1);
    repeat (5) @(negedge clk);
    check_eq("timeout_sticky", 32'(tx_error), 1);
    dead = 1'b0;
    do_frame("after_to", 8'h05, 8'd2, rand_buf(), 1'b0);

    // Collision: send mid-frame is ignored and not queued.
    fork
      do_frame("collide", 8'h06, 8'd4, rand_buf(), 1'b0);
      begin
        repeat (30) @(negedge clk);
        command = 8'h77; data_len = 8'd1; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
      end
    join
    got_q.delete();
    repeat (40) @(negedge clk);
    check_eq("no_queue", got_q.size(), 0);

    // Send held high: next frame starts right after FINISH.
    b = rand_buf();
    model(8'h07, 8'd2, b);
    got_q.delete();
    @(negedge clk);
    command = 8'h07; data_len = 8'd2; buffer = b; send = 1'b1;
    wait_done("held1");
    cmp_frame("held1");
    got_q.delete();
    @(negedge clk);
    @(negedge clk);
    check_eq("held_restart", 32'(busy), 1);
    send = 1'b0;
    wait_done("held2");
    cmp_frame("held2");

    // Reset mid-payload, then a clean frame.
    start_frame("rst_mid", 8'h08, 8'd10, rand_buf());
    for (int i = 0; i < 2000 && got_q.size() < 5; i++) @(negedge clk);
    check_eq("rst_mid_reached", 32'(got_q.size() >= 5), 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_transmit", 32'(transmit), 0);
    check_eq("rst_mid_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    do_frame("post_rst", 8'h09, 8'd5, rand_buf(), 1'b0);

    // Randomized frames.
    for (int n = 0; n < 10; n++) begin
      logic [7:0] l;
      l = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 40));
      do_frame($sformatf("rand%0d", n), 8'($urandom), l, rand_buf(), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
